// File: rtl/cbus_arbiter.sv
// Purpose: shares the single cbus memory port among N_REQ cache-side requesters
// (ICache, DCache, uncached). The grant is held until the final response beat.
// Latency: 1 cycle from a request seen in IDLE to oreq.valid. Responses pass
// through to the owner combinationally (0 cycles). There is a 1-cycle IDLE
// bubble after every last beat.
// Backpressure: the grant stays locked until iresp.ready && iresp.last.
// Losing requesters wait, and their oresps stay all-zero.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   ireqs      per-requester cbus requests
//   oresps     per-requester cbus responses (non-owners get '0)
//   oreq       request forwarded to the memory side ('0 while idle)
//   iresp      response from the memory side (ready, last, data)
//   busy       high while a grant is held
//   grant_idx  index of the current or most recent owner

package cbus_pkg;
    typedef enum logic [1:0] {
        MLEN1  = 2'd0,
        MLEN2  = 2'd1,
        MLEN4  = 2'd2,
        MLEN16 = 2'd3
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        mlen_t       len;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter #(
    parameter int N_REQ = 2,
    parameter bit RR    = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  cbus_pkg::cbus_req_t  [N_REQ-1:0]    ireqs,
    output cbus_pkg::cbus_resp_t [N_REQ-1:0]    oresps,
    output cbus_pkg::cbus_req_t                 oreq,
    input  cbus_pkg::cbus_resp_t                iresp,
    output logic                                busy,
    output logic [$clog2(N_REQ)-1:0]            grant_idx
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  sel, sel_nx;
    logic [IW-1:0]  ptr, ptr_nx;
    logic [IW-1:0]  win;
    logic [IW:0]    scan_idx;
    logic [N_REQ-1:0] vld;
    logic           any_vld;

    always_comb begin
        vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vld[i] = ireqs[i].valid;
        end
    end

    assign any_vld = |vld;

    // Winner scan. Walk from the far end back toward the start so that the
    // last hit is the first valid index in scan order. In round-robin mode
    // the scan starts at ptr and wraps modulo N_REQ. The sum is kept one bit
    // wider so that a non-power-of-2 N_REQ never yields an index >= N_REQ.
    always_comb begin
        win      = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = (RR ? {1'b0, ptr} : '0) + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(N_REQ)) begin
                scan_idx = scan_idx - (IW+1)'(N_REQ);
            end
            if (vld[scan_idx[IW-1:0]]) begin
                win = scan_idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next-state logic. Completion is driven only by the last flag; beats are
    // not counted. A stray response seen in IDLE is ignored.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (any_vld) begin
                    sel_nx   = win;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (iresp.ready && iresp.last) begin
                    state_nx = IDLE;
                    if (RR) begin
                        ptr_nx = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output routing. The owner's request goes out as-is, including a
    // dropped valid: the transaction is never aborted early.
    always_comb begin
        oreq   = '0;
        oresps = '0;
        if (state == BUSY) begin
            oreq        = ireqs[sel];
            oresps[sel] = iresp;
        end
    end

    assign busy      = (state == BUSY);
    assign grant_idx = sel;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter. It drives a round-robin instance (3 requesters) and
// a fixed-priority instance (2 requesters) from directed sequences. A
// transaction-level model predicts the outputs, and those predictions are
// checked every cycle on the falling edge.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t  [2:0] rr_reqs;
    cbus_resp_t [2:0] rr_oresps;
    cbus_req_t        rr_oreq;
    cbus_resp_t       rr_resp;
    logic             rr_busy;
    logic [1:0]       rr_gidx;

    cbus_req_t  [1:0] fp_reqs;
    cbus_resp_t [1:0] fp_oresps;
    cbus_req_t        fp_oreq;
    cbus_resp_t       fp_resp;
    logic             fp_busy;
    logic [0:0]       fp_gidx;

    int checks = 0;
    int failures = 0;

    cbus_arbiter #(.N_REQ(3), .RR(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(rr_reqs), .oresps(rr_oresps),
        .oreq(rr_oreq), .iresp(rr_resp), .busy(rr_busy), .grant_idx(rr_gidx)
    );

    cbus_arbiter #(.N_REQ(2), .RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(fp_reqs), .oresps(fp_oresps),
        .oreq(fp_oreq), .iresp(fp_resp), .busy(fp_busy), .grant_idx(fp_gidx)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cbus_req_t mk_req(input int id, input mlen_t len);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.addr  = 32'h1000_0000 | (32'(id) << 8);
        r.size  = 3'd2;
        r.len   = len;
        r.data  = 32'hD000_0000 | 32'(id);
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    // First valid requester in the order start, start+1, ... modulo n; -1 if none.
    function automatic int pick(input logic [2:0] v, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    // Transaction-level model: index 0 = round-robin instance, 1 = fixed priority.
    int         m_busy [2];
    int         m_own  [2];
    int         m_ptr  [2];
    int         m_w;
    logic [2:0] v_rr, v_fp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0;
                m_own[i]  = 0;
                m_ptr[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) v_rr[i] = rr_reqs[i].valid;
            v_fp = {1'b0, fp_reqs[1].valid, fp_reqs[0].valid};
            if (m_busy[0] == 0) begin
                m_w = pick(v_rr, 3, m_ptr[0]);
                if (m_w >= 0) begin
                    m_busy[0] = 1;
                    m_own[0]  = m_w;
                end
            end else if (rr_resp.ready && rr_resp.last) begin
                m_busy[0] = 0;
                m_ptr[0]  = (m_own[0] + 1) % 3;
            end
            if (m_busy[1] == 0) begin
                m_w = pick(v_fp, 2, 0);
                if (m_w >= 0) begin
                    m_busy[1] = 1;
                    m_own[1]  = m_w;
                end
            end else if (fp_resp.ready && fp_resp.last) begin
                m_busy[1] = 0;
            end
        end
    end

    cbus_req_t  e_req;
    cbus_resp_t e_resp;

    always @(negedge clk) begin
        e_req = (m_busy[0] != 0) ? rr_reqs[m_own[0]] : '0;
        chk("rr_oreq", 128'(rr_oreq), 128'(e_req));
        for (int j = 0; j < 3; j++) begin
            e_resp = (m_busy[0] != 0 && m_own[0] == j) ? rr_resp : '0;
            chk("rr_oresps", 128'(rr_oresps[j]), 128'(e_resp));
        end
        chk("rr_busy", 128'(rr_busy), 128'(m_busy[0] != 0));
        chk("rr_grant_idx", 128'(int'(rr_gidx)), 128'(m_own[0]));
        chk("rr_ptr", 128'(int'(dut_rr.ptr)), 128'(m_ptr[0]));

        e_req = (m_busy[1] != 0) ? fp_reqs[m_own[1]] : '0;
        chk("fp_oreq", 128'(fp_oreq), 128'(e_req));
        for (int j = 0; j < 2; j++) begin
            e_resp = (m_busy[1] != 0 && m_own[1] == j) ? fp_resp : '0;
            chk("fp_oresps", 128'(fp_oresps[j]), 128'(e_resp));
        end
        chk("fp_busy", 128'(fp_busy), 128'(m_busy[1] != 0));
        chk("fp_grant_idx", 128'(int'(fp_gidx)), 128'(m_own[1]));
    end

    initial begin
        int beats;
        int nz0;
        int alt_g [4] = '{0, 1, 0, 1};
        int alt_p [4] = '{2, 1, 2, 1};
        int wr_g  [2] = '{2, 0};
        int wr_p  [2] = '{2, 0};

        rr_reqs = '0; rr_resp = '0;
        fp_reqs = '0; fp_resp = '0;

        // Reset must act without a clock edge.
        #3 reset = 1'b1;
        #1;
        chk("rst_oreq", 128'(rr_oreq), 128'(0));
        chk("rst_oresps", 128'(rr_oresps), 128'(0));
        chk("rst_busy", 128'(rr_busy), 128'(0));
        chk("rst_gidx", 128'(int'(rr_gidx)), 128'(0));
        #18 reset = 1'b0;

        // Single 16-beat request from requester 1.
        @(posedge clk); #1;
        rr_reqs[1] = mk_req(1, MLEN16);
        @(negedge clk);
        chk("sr_valid_t0", 128'(rr_oreq.valid), 128'(0));
        beats = 0;
        nz0   = 0;
        for (int b = 1; b <= 16; b++) begin
            @(posedge clk); #1;
            rr_resp = mk_resp(1'b1, b == 16, 32'h100 + 32'(b));
            @(negedge clk);
            if (b == 1) chk("sr_valid_t1", 128'(rr_oreq.valid), 128'(1));
            if (rr_oresps[1].ready) beats++;
            if (rr_oresps[0] != '0) nz0++;
        end
        @(posedge clk); #1;
        rr_resp = '0;
        rr_reqs = '0;
        @(negedge clk);
        chk("sr_busy_after_last", 128'(rr_busy), 128'(0));
        chk("sr_beats", 128'(beats), 128'(16));
        chk("sr_other_zero", 128'(nz0), 128'(0));
        chk("sr_gidx", 128'(int'(rr_gidx)), 128'(1));
        chk("sr_ptr", 128'(int'(dut_rr.ptr)), 128'(2));

        // Round-robin alternation, single-beat transactions, both always valid.
        @(posedge clk); #1;
        rr_reqs[0] = mk_req(0, MLEN1);
        rr_reqs[1] = mk_req(1, MLEN1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                rr_resp = rr_oreq.valid ? mk_resp(1'b1, 1'b1, 32'hA0 + 32'(k)) : '0;
            end
            @(negedge clk);
            chk("rr_alt_valid", 128'(rr_oreq.valid), 128'(k % 2));
            if (k % 2 == 1) chk("rr_alt_grant", 128'(int'(rr_gidx)), 128'(alt_g[k/2]));
            else            chk("rr_alt_ptr", 128'(int'(dut_rr.ptr)), 128'(alt_p[k/2]));
        end
        @(posedge clk); #1;
        rr_reqs = '0;
        rr_resp = '0;
        @(negedge clk);
        chk("rr_alt_ptr_end", 128'(int'(dut_rr.ptr)), 128'(2));

        // Wrap of the scan past the top index (non-power-of-2 N_REQ).
        @(posedge clk); #1;
        rr_reqs[0] = mk_req(0, MLEN1);
        rr_reqs[2] = mk_req(2, MLEN1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                rr_resp = rr_oreq.valid ? mk_resp(1'b1, 1'b1, 32'hB0 + 32'(k)) : '0;
            end
            @(negedge clk);
            chk("wrap_valid", 128'(rr_oreq.valid), 128'(k % 2));
            if (k % 2 == 1) chk("wrap_grant", 128'(int'(rr_gidx)), 128'(wr_g[k/2]));
            else            chk("wrap_ptr", 128'(int'(dut_rr.ptr)), 128'(wr_p[k/2]));
        end
        @(posedge clk); #1;
        rr_reqs = '0;
        rr_resp = '0;
        @(negedge clk);
        chk("wrap_ptr_end", 128'(int'(dut_rr.ptr)), 128'(1));

        // Non-last beats: 5 beats, 3 gaps, then the last beat.
        @(posedge clk); #1;
        rr_reqs[1] = mk_req(1, MLEN16);
        beats = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c <= 5)      rr_resp = mk_resp(1'b1, 1'b0, 32'hC0 + 32'(c));
            else if (c <= 8) rr_resp = '0;
            else             rr_resp = mk_resp(1'b1, 1'b1, 32'hCF);
            @(negedge clk);
            chk("nl_busy", 128'(rr_busy), 128'(1));
            if (rr_oresps[1].ready) beats++;
        end
        @(posedge clk); #1;
        rr_reqs = '0;
        rr_resp = '0;
        @(negedge clk);
        chk("nl_idle_after", 128'(rr_busy), 128'(0));
        chk("nl_beats", 128'(beats), 128'(6));
        chk("nl_ptr", 128'(int'(dut_rr.ptr)), 128'(2));

        // Stray response while idle with no requests.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rr_resp = mk_resp(1'b1, 1'b1, 32'hEE);
            @(negedge clk);
            chk("stray_oresps", 128'(rr_oresps), 128'(0));
            chk("stray_busy", 128'(rr_busy), 128'(0));
        end
        @(posedge clk); #1;
        rr_resp = '0;
        @(negedge clk);
        chk("stray_ptr", 128'(int'(dut_rr.ptr)), 128'(2));
        chk("stray_idle", 128'(rr_busy), 128'(0));

        // Reset between edges at beat 4 of a 16-beat transaction.
        @(posedge clk); #1;
        rr_reqs[1] = mk_req(1, MLEN16);
        for (int b = 1; b <= 4; b++) begin
            @(posedge clk); #1;
            rr_resp = mk_resp(1'b1, 1'b0, 32'h400 + 32'(b));
        end
        #2 reset = 1'b1;
        rr_reqs = '0;
        rr_resp = '0;
        #1;
        chk("mrst_valid", 128'(rr_oreq.valid), 128'(0));
        chk("mrst_busy", 128'(rr_busy), 128'(0));
        chk("mrst_gidx", 128'(int'(rr_gidx)), 128'(0));
        chk("mrst_ptr", 128'(int'(dut_rr.ptr)), 128'(0));
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        rr_reqs[2] = mk_req(2, MLEN1);
        @(negedge clk);
        chk("mrst_new_t0", 128'(rr_oreq.valid), 128'(0));
        @(posedge clk); #1;
        rr_resp = mk_resp(1'b1, 1'b1, 32'h55);
        @(negedge clk);
        chk("mrst_new_t1", 128'(rr_oreq.valid), 128'(1));
        chk("mrst_new_gidx", 128'(int'(rr_gidx)), 128'(2));
        @(posedge clk); #1;
        rr_reqs = '0;
        rr_resp = '0;
        @(negedge clk);
        chk("mrst_new_ptr", 128'(int'(dut_rr.ptr)), 128'(0));

        // Fixed priority: requester 0 wins while valid, requester 1 starves.
        @(posedge clk); #1;
        fp_reqs[0] = mk_req(0, MLEN1);
        fp_reqs[1] = mk_req(1, MLEN1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                fp_resp = fp_oreq.valid ? mk_resp(1'b1, 1'b1, 32'hF0 + 32'(k)) : '0;
            end
            @(negedge clk);
            chk("fp_valid", 128'(fp_oreq.valid), 128'(k % 2));
            chk("fp_starve_resp1", 128'(fp_oresps[1]), 128'(0));
            if (k % 2 == 1) chk("fp_grant0", 128'(int'(fp_gidx)), 128'(0));
        end
        @(posedge clk); #1;
        fp_reqs[0] = '0;
        fp_resp    = '0;
        @(negedge clk);
        chk("fp_drop_idle", 128'(fp_busy), 128'(0));
        @(posedge clk); #1;
        fp_resp = mk_resp(1'b1, 1'b1, 32'h77);
        @(negedge clk);
        chk("fp_req1_valid", 128'(fp_oreq.valid), 128'(1));
        chk("fp_req1_grant", 128'(int'(fp_gidx)), 128'(1));
        chk("fp_req1_resp", 128'(fp_oresps[1]), 128'(mk_resp(1'b1, 1'b1, 32'h77)));
        @(posedge clk); #1;
        fp_reqs = '0;
        fp_resp = '0;
        @(negedge clk);
        chk("fp_end_idle", 128'(fp_busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
